// File: rtl/bank_rd_pkg.sv
// Shared defaults and width helper for the banked register-file read arbiter.
package bank_rd_pkg;

  localparam int unsigned NUM_BANKS_DEF    = 3;
  localparam int unsigned SIZE_BANKI_DEF   = 32;
  localparam int unsigned NUM_RD_PORTS_DEF = 3;
  localparam int unsigned DATA_W_DEF       = 32;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/bank_rd_arbiter_if.sv
// Read-port and bank-side signal bundle of the banked read arbiter.
interface bank_rd_arbiter_if
  import bank_rd_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = NUM_BANKS_DEF,
  parameter int unsigned SIZE_BANKI   = SIZE_BANKI_DEF,
  parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
);
  localparam int unsigned SHIRINA_BANKI = $clog2(SIZE_BANKI);
  localparam int unsigned BANK_W        = clog2_min1(NUM_BANKS);

  logic [NUM_RD_PORTS-1:0]                    req;
  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]        rbank;
  logic [NUM_RD_PORTS-1:0][SHIRINA_BANKI-1:0] ra;
  logic [NUM_RD_PORTS-1:0]                    gnt;
  logic [NUM_RD_PORTS-1:0]                    rerr;
  logic [NUM_BANKS-1:0]                       re_banki;
  logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]    ra_banki;
  logic [NUM_BANKS-1:0][DATA_W-1:0]           rd_banki;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]        rdata;
  logic [NUM_RD_PORTS-1:0]                    rvld;

  modport master (
    output req, rbank, ra, rd_banki,
    input  gnt, rerr, re_banki, ra_banki, rdata, rvld
  );

  modport slave (
    input  req, rbank, ra, rd_banki,
    output gnt, rerr, re_banki, ra_banki, rdata, rvld
  );

endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at an internal pointer.
module rr_arb #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic          found;
  int unsigned   idx;

  // Ascending search from ptr with wrap; pointer moves just past the winner.
  always_comb begin
    gnt   = '0;
    ptr_n = ptr;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found           = 1'b1;
        gnt[PW'(idx)]   = 1'b1;
        ptr_n           = (idx + 1 >= N) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_n;
  end

endmodule

// File: rtl/bank_rd_arbiter.sv
// Per-bank round-robin read arbitration with a two-stage read-return pipeline.
module bank_rd_arbiter
  import bank_rd_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = NUM_BANKS_DEF,
  parameter int unsigned SIZE_BANKI   = SIZE_BANKI_DEF,
  parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  bank_rd_arbiter_if.slave bus
);

  localparam int unsigned SHIRINA_BANKI = $clog2(SIZE_BANKI);
  localparam int unsigned BANK_W        = clog2_min1(NUM_BANKS);
  localparam int unsigned PORT_W        = clog2_min1(NUM_RD_PORTS);

  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]  bank_req;
  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]  bank_gnt;
  logic [NUM_RD_PORTS-1:0]                 bad_bank;
  logic [NUM_RD_PORTS-1:0]                 gnt_any;
  logic [NUM_BANKS-1:0][PORT_W-1:0]        win_idx;
  logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0] win_ra;
  logic [NUM_BANKS-1:0][PORT_W-1:0]        s1_port;
  logic [NUM_RD_PORTS-1:0]                 s2_vld;
  logic [NUM_RD_PORTS-1:0]                 s2_vld_n;
  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]     s2_bank;
  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]     s2_bank_n;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     rdata_q;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     rdata_c;

  // Steer each request to its bank; gating with rst_n keeps gnt low in reset.
  always_comb begin
    bank_req = '0;
    bad_bank = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if ({1'b0, bus.rbank[p]} >= (BANK_W+1)'(NUM_BANKS))
        bad_bank[p] = bus.req[p] & rst_n;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bus.rbank[p] == BANK_W'(b))
          bank_req[b][p] = bus.req[p] & rst_n;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arb #(
      .N  (NUM_RD_PORTS),
      .PW (PORT_W)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );
  end

  // Merge per-bank grants and encode each bank's winner and its address.
  always_comb begin
    gnt_any = '0;
    win_idx = '0;
    win_ra  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_any = gnt_any | bank_gnt[b];
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          win_idx[b] = PORT_W'(p);
          win_ra[b]  = bus.ra[p];
        end
      end
    end
  end

  assign bus.gnt = gnt_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rerr <= '0;
    else        bus.rerr <= bad_bank;
  end

  // Stage 1: bank read enable/address; address holds on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.re_banki <= '0;
      bus.ra_banki <= '0;
      s1_port      <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bus.re_banki[b] <= |bank_gnt[b];
        if (|bank_gnt[b]) begin
          bus.ra_banki[b] <= win_ra[b];
          s1_port[b]      <= win_idx[b];
        end
      end
    end
  end

  // Route each active bank read back to the port that issued it.
  always_comb begin
    s2_vld_n  = '0;
    s2_bank_n = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (bus.re_banki[b] && s1_port[b] == PORT_W'(p)) begin
          s2_vld_n[p]  = 1'b1;
          s2_bank_n[p] = BANK_W'(b);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= '0;
      s2_bank <= '0;
    end else begin
      s2_vld  <= s2_vld_n;
      s2_bank <= s2_bank_n;
    end
  end

  // Bank data arrives in the rvld cycle itself; the hold register covers idle cycles.
  always_comb begin
    rdata_c = rdata_q;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (s2_vld[p]) rdata_c[p] = bus.rd_banki[s2_bank[p]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_c;
  end

  assign bus.rdata = rdata_c;
  assign bus.rvld  = s2_vld;

endmodule

// File: tb/tb_bank_rd_arbiter.sv
// Self-checking bench for bank_rd_arbiter: directed scenarios plus a cycle-level reference model.
module tb_bank_rd_arbiter;

  localparam int unsigned NB = 3;
  localparam int unsigned NP = 3;
  localparam int unsigned SZ = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned BW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  bank_rd_arbiter_if #(.NUM_BANKS(NB), .SIZE_BANKI(SZ), .NUM_RD_PORTS(NP), .DATA_W(DW)) bus ();

  bank_rd_arbiter #(.NUM_BANKS(NB), .SIZE_BANKI(SZ), .NUM_RD_PORTS(NP), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memval(input int b, input int a);
    return DW'(32'hD000_0000 + b * 32'h0001_0000 + a * 32'h0000_0101);
  endfunction

  // Bank storage: registered read, data appears the cycle after re_banki.
  logic [NB-1:0][DW-1:0] rd_q = '0;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (bus.re_banki[b]) rd_q[b] <= memval(b, int'(bus.ra_banki[b]));
  end
  assign bus.rd_banki = rd_q;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    else passes++;
  endtask

  // Reference model state.
  int             m_ptr   [NB];
  logic [NB-1:0]  m_s1vld;
  int             m_s1port[NB];
  int             m_s1ra  [NB];
  logic [AW-1:0]  m_ra    [NB];
  logic [NP-1:0]  m_s2vld;
  logic [DW-1:0]  m_s2data[NP];
  logic [DW-1:0]  m_rdata [NP];
  logic [NP-1:0]  m_rerr;
  int             m_wait  [NP];

  task automatic model_clear();
    m_s1vld = '0; m_s2vld = '0; m_rerr = '0;
    for (int b = 0; b < NB; b++) begin
      m_ptr[b] = 0; m_s1port[b] = 0; m_s1ra[b] = 0; m_ra[b] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      m_s2data[p] = '0; m_rdata[p] = '0; m_wait[p] = 0;
    end
  endtask

  initial model_clear();

  always @(negedge clk) begin
    logic [NP-1:0] eg;
    int            win [NB];
    logic          valid_b;
    if (!rst_n) begin
      model_clear();
      chk("rst_gnt", 64'(bus.gnt), 64'd0);
      chk("rst_re", 64'(bus.re_banki), 64'd0);
      chk("rst_ra", 64'(bus.ra_banki), 64'd0);
      chk("rst_rerr", 64'(bus.rerr), 64'd0);
      chk("rst_rvld", 64'(bus.rvld), 64'd0);
      chk("rst_rdata", 64'(|bus.rdata), 64'd0);
    end else begin
      // Round-robin winner per bank, searched from that bank's pointer.
      eg = '0;
      for (int b = 0; b < NB; b++) begin
        win[b] = -1;
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_ptr[b] + k) % NP;
          if (win[b] < 0 && bus.req[p] && int'(bus.rbank[p]) == b) win[b] = p;
        end
        if (win[b] >= 0) eg[win[b]] = 1'b1;
      end
      for (int b = 0; b < NB; b++) if (m_s1vld[b]) m_ra[b] = AW'(m_s1ra[b]);
      for (int p = 0; p < NP; p++) if (m_s2vld[p]) m_rdata[p] = m_s2data[p];

      chk("gnt", 64'(bus.gnt), 64'(eg));
      chk("re_banki", 64'(bus.re_banki), 64'(m_s1vld));
      for (int b = 0; b < NB; b++) chk($sformatf("ra_banki[%0d]", b), 64'(bus.ra_banki[b]), 64'(m_ra[b]));
      chk("rerr", 64'(bus.rerr), 64'(m_rerr));
      chk("rvld", 64'(bus.rvld), 64'(m_s2vld));
      for (int p = 0; p < NP; p++) chk($sformatf("rdata[%0d]", p), 64'(bus.rdata[p]), 64'(m_rdata[p]));

      // Starvation: a held valid request must win within NP cycles.
      for (int p = 0; p < NP; p++) begin
        valid_b = bus.req[p] && (int'(bus.rbank[p]) < NB);
        if (valid_b && !bus.gnt[p]) m_wait[p]++;
        else                        m_wait[p] = 0;
        if (valid_b) chk($sformatf("starve[%0d]", p), 64'(m_wait[p] < NP), 64'd1);
      end

      // Advance pipeline one cycle.
      m_s2vld = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_s1vld[b]) begin
          m_s2vld[m_s1port[b]]  = 1'b1;
          m_s2data[m_s1port[b]] = memval(b, m_s1ra[b]);
        end
      end
      for (int b = 0; b < NB; b++) begin
        m_s1vld[b] = (win[b] >= 0);
        if (win[b] >= 0) begin
          m_s1port[b] = win[b];
          m_s1ra[b]   = int'(bus.ra[win[b]]);
          m_ptr[b]    = (win[b] + 1) % NP;
        end
      end
      for (int p = 0; p < NP; p++) m_rerr[p] = bus.req[p] && (int'(bus.rbank[p]) >= NB);
    end
  end

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic set(input int p, input logic r, input int bk, input int a);
    bus.req[p]   = r;
    bus.rbank[p] = BW'(bk);
    bus.ra[p]    = AW'(a);
  endtask

  initial begin
    int            gcount, rcount;
    logic [NP-1:0] g_prev;
    logic [NP-1:0] act;
    int            bk;
    rst_n = 1'b0;
    bus.req = '0; bus.rbank = '0; bus.ra = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three ports on bank 1: grants rotate 0,1,2 and data returns in order.
    set(0, 1, 1, 5); set(1, 1, 1, 6); set(2, 1, 1, 7);
    mid(); chk("t1_gnt0", 64'(bus.gnt), 64'b001);
    nxt(); set(0, 0, 1, 5);
    mid(); chk("t1_gnt1", 64'(bus.gnt), 64'b010);
           chk("t1_re", 64'(bus.re_banki), 64'b010);
           chk("t1_ra5", 64'(bus.ra_banki[1]), 64'd5);
    nxt(); set(1, 0, 1, 6);
    mid(); chk("t1_gnt2", 64'(bus.gnt), 64'b100);
           chk("t1_ra6", 64'(bus.ra_banki[1]), 64'd6);
           chk("t1_rvld0", 64'(bus.rvld), 64'b001);
           chk("t1_rdata0", 64'(bus.rdata[0]), 64'h0000_0000_D001_0505);
    nxt(); set(2, 0, 1, 7);
    mid(); chk("t1_ra7", 64'(bus.ra_banki[1]), 64'd7);
           chk("t1_rvld1", 64'(bus.rvld), 64'b010);
    nxt();
    mid(); chk("t1_rvld2", 64'(bus.rvld), 64'b100);
           chk("t1_rdata2", 64'(bus.rdata[2]), 64'h0000_0000_D001_0707);

    // Two ports on different banks granted together.
    nxt(); set(0, 1, 0, 3); set(1, 1, 2, 9);
    mid(); chk("t2_gnt", 64'(bus.gnt), 64'b011);
    nxt(); set(0, 0, 0, 3); set(1, 0, 2, 9);
    mid(); chk("t2_re", 64'(bus.re_banki), 64'b101);
    nxt();
    mid(); chk("t2_rvld", 64'(bus.rvld), 64'b011);
           chk("t2_rdata0", 64'(bus.rdata[0]), 64'h0000_0000_D000_0303);
           chk("t2_rdata1", 64'(bus.rdata[1]), 64'h0000_0000_D002_0909);

    // Invalid bank: never granted, rerr while held.
    nxt(); set(2, 1, 3, 4);
    mid(); chk("t3_gnt_first", 64'(bus.gnt[2]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      mid(); chk("t3_gnt", 64'(bus.gnt[2]), 64'd0);
             chk("t3_rerr", 64'(bus.rerr[2]), 64'd1);
             chk("t3_rvld", 64'(bus.rvld[2]), 64'd0);
    end
    nxt(); set(2, 0, 0, 0);
    mid(); chk("t3_rerr_last", 64'(bus.rerr[2]), 64'd1);
    nxt();
    mid(); chk("t3_rerr_off", 64'(bus.rerr), 64'd0);

    // Reset with a read in flight drops it and rewinds the pointers.
    nxt(); set(1, 1, 0, 2);
    mid(); chk("t4_gnt", 64'(bus.gnt), 64'b010);
    nxt(); set(1, 0, 0, 2); rst_n = 1'b0;
    mid(); chk("t4_rst_re", 64'(bus.re_banki), 64'd0);
    nxt(); rst_n = 1'b1; set(0, 1, 0, 1); set(1, 1, 0, 4);
    mid(); chk("t4_gnt_p0", 64'(bus.gnt), 64'b001);
           chk("t4_no_rvld", 64'(bus.rvld), 64'd0);
    nxt(); set(0, 0, 0, 1);
    mid(); chk("t4_gnt_p1", 64'(bus.gnt), 64'b010);
           chk("t4_no_rvld2", 64'(bus.rvld), 64'd0);
    nxt(); set(1, 0, 0, 4);
    mid(); chk("t4_rvld_p0", 64'(bus.rvld), 64'b001);
    nxt();
    mid(); chk("t4_rvld_p1", 64'(bus.rvld), 64'b010);
           chk("t4_rdata1", 64'(bus.rdata[1]), 64'h0000_0000_D000_0404);

    // Streaming 32 reads from one port, no bubbles.
    gcount = 0; rcount = 0;
    for (int i = 0; i < 32; i++) begin
      nxt(); set(0, 1, 0, i);
      mid();
      if (bus.gnt[0]) gcount++;
      if (bus.rvld[0]) rcount++;
    end
    nxt(); set(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mid();
      if (bus.rvld[0]) rcount++;
      nxt();
    end
    chk("t5_gnt_count", 64'(gcount), 64'd32);
    chk("t5_rvld_count", 64'(rcount), 64'd32);
    chk("t5_rdata_last", 64'(bus.rdata[0]), 64'h0000_0000_D000_1F1F);

    // Random traffic; requests are held until granted, invalid ones drop at random.
    act = '0; g_prev = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (act[p] && (g_prev[p] || (int'(bus.rbank[p]) >= NB && $urandom_range(0, 3) == 0))) begin
          act[p] = 1'b0;
          set(p, 0, int'(bus.rbank[p]), int'(bus.ra[p]));
        end
        if (!act[p] && $urandom_range(0, 1) == 1) begin
          act[p] = 1'b1;
          bk = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, NB - 1));
          set(p, 1, bk, int'($urandom_range(0, SZ - 1)));
        end
      end
      mid(); g_prev = bus.gnt;
      nxt();
    end
    bus.req = '0;
    repeat (4) nxt();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bank_rd_arbiter.md
BANK_RD_ARBITER -- requirements
Module: bank_rd_arbiter

Interface
REQ-001 Parameter NUM_BANKS, default 3: number of register-file banks.
REQ-002 Parameter SIZE_BANKI, default 32: words per bank.
REQ-003 Parameter NUM_RD_PORTS, default 3: number of read ports.
REQ-004 Parameter DATA_W, default 32: read-data width.
REQ-005 Derived localparams SHIRINA_BANKI = $clog2(SIZE_BANKI), BANK_W = max(1,$clog2(NUM_BANKS)), PORT_W = max(1,$clog2(NUM_RD_PORTS)); not overridable.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 req  input  [NUM_RD_PORTS]  per-port read request; held until granted.
REQ-009 rbank  input  [NUM_RD_PORTS][BANK_W]  target bank per port.
REQ-010 ra  input  [NUM_RD_PORTS][SHIRINA_BANKI]  word address within bank per port.
REQ-011 gnt  output  [NUM_RD_PORTS]  combinational grant, same cycle as winning req.
REQ-012 rerr  output  [NUM_RD_PORTS]  registered one-cycle pulse: request named bank >= NUM_BANKS.
REQ-013 re_banki  output  [NUM_BANKS]  registered bank read enable.
REQ-014 ra_banki  output  [NUM_BANKS][SHIRINA_BANKI]  registered bank read address.
REQ-015 rd_banki  input  [NUM_BANKS][DATA_W]  bank read data, valid one cycle after re_banki.
REQ-016 rdata  output  [NUM_RD_PORTS][DATA_W]  returned read data.
REQ-017 rvld  output  [NUM_RD_PORTS]  rdata valid strobe.

Function
REQ-018 Each bank arbitrates independently among ports with req=1 and valid rbank equal to that bank.
REQ-019 Arbitration SHALL be round-robin: search starts at bank pointer ptr[b], ascending, wrapping NUM_RD_PORTS-1 -> 0.
REQ-020 At most one gnt per bank per cycle; a port is granted by at most one bank; ports to different banks granted in same cycle.
REQ-021 On grant to port p at bank b: ptr[b] <= (p+1) mod NUM_RD_PORTS; no grant -> ptr[b] unchanged.
REQ-022 Cycle N grant of port p to bank b -> cycle N+1 re_banki[b]=1, ra_banki[b]=ra[p] sampled at N.
REQ-023 Cycle N+2: rvld[p]=1, rdata[p]=rd_banki[b] sampled at N+2 (total latency 2); pipeline tracks port index and bank per stage.
REQ-024 Back-to-back grants to same port fully pipelined: one rvld per grant, in grant order, no bubbles.
REQ-025 Bank with no grant at N: re_banki[b]=0 at N+1, ra_banki[b] holds previous value.
REQ-026 rvld=0 cycles: rdata[p] holds previous value.
REQ-027 Invalid rbank (>= NUM_BANKS): never granted, rerr[p]=1 at N+1, no rvld; rerr repeats each cycle req persists.
REQ-028 req=0 -> gnt=0 for that port regardless of pointer.
REQ-029 NUM_RD_PORTS=1: port always wins; pointer logic degenerates, no X.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear ptr[*], re_banki, ra_banki, rerr, rvld, rdata, and pipeline valid bits to 0.
REQ-031 Reads in flight at reset SHALL be dropped: no rvld after rst_n release for grants issued before reset.
REQ-032 gnt is 0 while rst_n=0.
REQ-033 First arbitration after release starts at port 0 for every bank.

Structure
REQ-034 Package bank_rd_pkg holds default parameter values and the width-helper function (max(1,$clog2(n))).
REQ-035 One sub-module rr_arb (NUM_RD_PORTS requests in, one-hot grant out, internal pointer) instantiated once per bank by generate loop.
REQ-036 Grant-to-index encoding and return-path mux in top level; no latches; one always_ff per register group.

Verification
REQ-037 Defaults; ports 0,1,2 req bank 1, ra=5,6,7, held -> gnt order 0,1,2 in cycles N..N+2; ra_banki[1]=5,6,7 at N+1..N+3; rvld order 0,1,2.
REQ-038 Port 0 bank 0 ra=3, port 1 bank 2 ra=9 same cycle -> both gnt at N; re_banki=3'b101 at N+1; rvld[0],rvld[1] at N+2 with rd_banki[0],[2].
REQ-039 Port 2 rbank=3 -> gnt[2]=0 every cycle, rerr[2]=1 from N+1 while held, no rvld[2].
REQ-040 Grant port 1 bank 0, assert rst_n=0 at N+1 for one cycle -> all outputs 0 immediately, no rvld[1] after release; next grant from port 0.
REQ-041 Port 0 continuous req bank 0 with ra=0..31 incrementing, others idle -> gnt every cycle, 32 rvld back-to-back, rdata matching model.
REQ-042 Random req/rbank/ra for 10k cycles vs reference model -> no starvation (every held req granted within NUM_RD_PORTS cycles), exact rdata/rvld match.
